// File: rtl/rc4_pkg.sv
// Shared types and default widths for the RC4 key-search datapath.
// The phase encoding below is what the sequencer exposes on phase_tap.
package rc4_pkg;

  localparam int RC4_RAM_WIDTH  = 8;
  localparam int RC4_RAM_LENGTH = 8;
  localparam int RC4_KEY_LENGTH = 3;

  typedef enum logic [3:0] {
    ST_IDLE     = 4'd0,
    ST_INIT_GO  = 4'd1,
    ST_INIT_RUN = 4'd2,
    ST_SHUF_GO  = 4'd3,
    ST_SHUF_RUN = 4'd4,
    ST_DEC_GO   = 4'd5,
    ST_DEC_RUN  = 4'd6,
    ST_NEXT_KEY = 4'd7,
    ST_DONE     = 4'd8
  } seq_state_t;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_INIT = 2'd1,
    OWN_SHUF = 2'd2,
    OWN_DEC  = 2'd3
  } ram_owner_t;

  typedef logic [RC4_KEY_LENGTH-1:0][RC4_RAM_WIDTH-1:0] key_bytes_t;

endpackage

// File: rtl/rc4_ram_mux.sv
// Three-way combinational port mux onto the single-port S RAM.
// With no owner the RAM sees address 0, data 0 and no write.
module rc4_ram_mux
  import rc4_pkg::*;
#(
  parameter int AW = RC4_RAM_LENGTH,
  parameter int DW = RC4_RAM_WIDTH
) (
  input  ram_owner_t    owner_i,
  input  logic [AW-1:0] init_addr_i,
  input  logic [DW-1:0] init_data_i,
  input  logic          init_we_i,
  input  logic [AW-1:0] shuf_addr_i,
  input  logic [DW-1:0] shuf_data_i,
  input  logic          shuf_we_i,
  input  logic [AW-1:0] dec_addr_i,
  input  logic [DW-1:0] dec_data_i,
  input  logic          dec_we_i,
  output logic [AW-1:0] ram_address_o,
  output logic [DW-1:0] ram_data_o,
  output logic          ram_wren_o
);

  always_comb begin
    ram_address_o = '0;
    ram_data_o    = '0;
    ram_wren_o    = 1'b0;
    case (owner_i)
      OWN_INIT: begin
        ram_address_o = init_addr_i;
        ram_data_o    = init_data_i;
        ram_wren_o    = init_we_i;
      end
      OWN_SHUF: begin
        ram_address_o = shuf_addr_i;
        ram_data_o    = shuf_data_i;
        ram_wren_o    = shuf_we_i;
      end
      OWN_DEC: begin
        ram_address_o = dec_addr_i;
        ram_data_o    = dec_data_i;
        ram_wren_o    = dec_we_i;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/rc4_ram_sequencer.sv
// Phase controller for the RC4 key search: runs init, shuffle and decrypt
// per candidate key, steps the key, and hands the shared S RAM to one client.
module rc4_ram_sequencer
  import rc4_pkg::*;
#(
  parameter int RAM_WIDTH  = RC4_RAM_WIDTH,
  parameter int RAM_LENGTH = RC4_RAM_LENGTH,
  parameter int KEY_LENGTH = RC4_KEY_LENGTH,
  parameter logic [KEY_LENGTH*RAM_WIDTH-1:0] KEY_MIN = '0,
  parameter logic [KEY_LENGTH*RAM_WIDTH-1:0] KEY_MAX = 24'h3FFFFF
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic                                 start,
  output logic                                 busy,
  output logic                                 done,
  output logic                                 found,
  output logic [KEY_LENGTH-1:0][RAM_WIDTH-1:0] key_out,
  output logic                                 init_start,
  output logic                                 shuf_start,
  output logic                                 dec_start,
  input  logic                                 init_done,
  input  logic                                 shuf_done,
  input  logic                                 dec_done,
  input  logic                                 dec_valid,
  input  logic [RAM_LENGTH-1:0]                init_addr,
  input  logic [RAM_LENGTH-1:0]                shuf_addr,
  input  logic [RAM_LENGTH-1:0]                dec_addr,
  input  logic [RAM_WIDTH-1:0]                 init_data,
  input  logic [RAM_WIDTH-1:0]                 shuf_data,
  input  logic [RAM_WIDTH-1:0]                 dec_data,
  input  logic                                 init_we,
  input  logic                                 shuf_we,
  input  logic                                 dec_we,
  output logic [RAM_LENGTH-1:0]                ram_address,
  output logic [RAM_WIDTH-1:0]                 ram_data,
  output logic                                 ram_wren,
  output logic [3:0]                           phase_tap
);

  localparam int KEY_W = KEY_LENGTH * RAM_WIDTH;

  seq_state_t       state_q, state_d;
  logic [KEY_W-1:0] key_q, key_d;
  logic             done_q, done_d;
  logic             found_q, found_d;
  ram_owner_t       owner;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      key_q   <= KEY_MIN;
      done_q  <= 1'b0;
      found_q <= 1'b0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      done_q  <= done_d;
      found_q <= found_d;
    end
  end

  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    done_d  = done_q;
    found_d = found_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          state_d = ST_INIT_GO;
          key_d   = KEY_MIN;
          done_d  = 1'b0;
          found_d = 1'b0;
        end
      end
      ST_INIT_GO:  state_d = ST_INIT_RUN;
      ST_INIT_RUN: if (init_done) state_d = ST_SHUF_GO;
      ST_SHUF_GO:  state_d = ST_SHUF_RUN;
      ST_SHUF_RUN: if (shuf_done) state_d = ST_DEC_GO;
      ST_DEC_GO:   state_d = ST_DEC_RUN;
      ST_DEC_RUN: begin
        // >= rather than == so an inverted range ends on the first failure.
        if (dec_done) begin
          if (dec_valid) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
            found_d = 1'b1;
          end else if (key_q >= KEY_MAX) begin
            state_d = ST_DONE;
            done_d  = 1'b1;
            found_d = 1'b0;
          end else begin
            state_d = ST_NEXT_KEY;
          end
        end
      end
      ST_NEXT_KEY: begin
        key_d   = key_q + KEY_W'(1);
        state_d = ST_INIT_GO;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    init_start = (state_q == ST_INIT_GO);
    shuf_start = (state_q == ST_SHUF_GO);
    dec_start  = (state_q == ST_DEC_GO);
    busy       = (state_q != ST_IDLE) && (state_q != ST_DONE);
    owner      = OWN_NONE;
    case (state_q)
      ST_INIT_GO, ST_INIT_RUN: owner = OWN_INIT;
      ST_SHUF_GO, ST_SHUF_RUN: owner = OWN_SHUF;
      ST_DEC_GO,  ST_DEC_RUN:  owner = OWN_DEC;
      default:                 owner = OWN_NONE;
    endcase
  end

  // Byte 0 of key_out carries the most significant byte of the counter.
  always_comb begin
    for (int i = 0; i < KEY_LENGTH; i++) begin
      key_out[i] = key_q[(KEY_LENGTH-1-i)*RAM_WIDTH +: RAM_WIDTH];
    end
  end

  assign done      = done_q;
  assign found     = found_q;
  assign phase_tap = state_q;

  rc4_ram_mux #(
    .AW(RAM_LENGTH),
    .DW(RAM_WIDTH)
  ) u_mux (
    .owner_i      (owner),
    .init_addr_i  (init_addr),
    .init_data_i  (init_data),
    .init_we_i    (init_we),
    .shuf_addr_i  (shuf_addr),
    .shuf_data_i  (shuf_data),
    .shuf_we_i    (shuf_we),
    .dec_addr_i   (dec_addr),
    .dec_data_i   (dec_data),
    .dec_we_i     (dec_we),
    .ram_address_o(ram_address),
    .ram_data_o   (ram_data),
    .ram_wren_o   (ram_wren)
  );

endmodule
